// File: rtl/paramest_nn_div_pkg.sv
// Shared widths, FSM state type and magnitude helper
// for the ParamEst NN sequential signed divider.
package paramest_nn_div_pkg;

   localparam int DIVIDEND_WIDTH = 28;
   localparam int DIVISOR_WIDTH  = 12;
   localparam int QUOT_WIDTH     = 16;
   localparam int CNT_WIDTH      = $clog2(DIVIDEND_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

   // Magnitude of a sign-extended value; one extra bit
   // keeps the most negative input exact.
   function automatic logic [DIVIDEND_WIDTH-1:0] abs_ext(
      input logic signed [DIVIDEND_WIDTH:0] v
   );
      return DIVIDEND_WIDTH'(v[DIVIDEND_WIDTH] ? -v : v);
   endfunction

endpackage

// File: rtl/paramest_nn_div_step.sv
// One restoring division iteration: shift in a dividend
// bit, trial-subtract the divisor, keep or restore.
module paramest_nn_div_step
   import paramest_nn_div_pkg::*;
(
   input  logic [DIVISOR_WIDTH-1:0] i_rem,
   input  logic [DIVISOR_WIDTH-1:0] i_dsr,
   input  logic                     i_bit,
   output logic                     o_qbit,
   output logic [DIVISOR_WIDTH-1:0] o_rem
);

   logic [DIVISOR_WIDTH:0]   w_shift;
   logic [DIVISOR_WIDTH-1:0] w_diff;

   // rem < dsr, so the shifted value is < 2*dsr and a
   // successful difference always fits DIVISOR_WIDTH bits.
   always_comb begin
      w_shift = {i_rem, i_bit};
      w_diff  = w_shift[DIVISOR_WIDTH-1:0] - i_dsr;
      o_qbit  = (w_shift >= {1'b0, i_dsr});
      o_rem   = o_qbit ? w_diff : w_shift[DIVISOR_WIDTH-1:0];
   end

endmodule

// File: rtl/paramest_nn_div_28s_12s_16u_seq.sv
// Sequential 28s / 12s -> 16u restoring divider.
// Build option: PARAMEST_DIV_SATURATE_EN (saturating quotient).
module paramest_nn_div_28s_12s_16u_seq
   import paramest_nn_div_pkg::*;
(
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOT_WIDTH-1:0]     quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      ovf,
   output logic                      dbz
);

   localparam int DW = DIVIDEND_WIDTH;
   localparam int SW = DIVISOR_WIDTH;
   localparam int QW = QUOT_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DW);

`ifdef PARAMEST_DIV_SATURATE_EN
   localparam logic [QW-1:0] DBZ_Q = '1;
`else
   localparam logic [QW-1:0] DBZ_Q = '0;
`endif

   div_state_t            r_state;
   div_state_t            w_state_nxt;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [DW-1:0]         r_dnd;
   logic [SW-1:0]         r_dsr;
   logic [SW-1:0]         r_prem;
   logic [DW-1:0]         r_q;
   logic                  r_qsign;
   logic                  r_rsign;
   logic [QW-1:0]         r_quot;
   logic [SW-1:0]         r_rem;
   logic                  r_ovf;
   logic                  r_dbz;

   logic                  w_qbit;
   logic [SW-1:0]         w_prem;
   logic                  w_ovf;
   logic [QW-1:0]         w_qwrap;
   logic [QW-1:0]         w_quot;
   logic [SW-1:0]         w_rem;
   logic                  w_dsr_zero;

   paramest_nn_div_step u_step (
      .i_rem  (r_prem),
      .i_dsr  (r_dsr),
      .i_bit  (r_dnd[DW-1]),
      .o_qbit (w_qbit),
      .o_rem  (w_prem)
   );

   assign w_dsr_zero = (divisor == '0);

   // Sign fix-up and optional saturation of the final result.
   always_comb begin
      w_ovf   = (r_qsign & (|r_q)) | (|r_q[DW-1:QW]);
      w_qwrap = r_qsign ? -r_q[QW-1:0] : r_q[QW-1:0];
      w_rem   = r_rsign ? -r_prem : r_prem;
`ifdef PARAMEST_DIV_SATURATE_EN
      w_quot  = w_ovf ? (r_qsign ? '0 : '1) : w_qwrap;
`else
      w_quot  = w_qwrap;
`endif
   end

   // FSM state register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_state <= IDLE;
      else           r_state <= w_state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: if (in_valid) w_state_nxt = w_dsr_zero ? DONE : CALC;
         CALC: if (r_cnt == LAST) w_state_nxt = DONE;
         DONE: if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand latch, iteration datapath and result registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_cnt   <= '0;
         r_dnd   <= '0;
         r_dsr   <= '0;
         r_prem  <= '0;
         r_q     <= '0;
         r_qsign <= 1'b0;
         r_rsign <= 1'b0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_ovf   <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: if (in_valid) begin
               r_dnd   <= abs_ext({dividend[DW-1], dividend});
               r_dsr   <= SW'(abs_ext(
                             {{(DW+1-SW){divisor[SW-1]}}, divisor}));
               r_qsign <= dividend[DW-1] ^ divisor[SW-1];
               r_rsign <= dividend[DW-1];
               r_cnt   <= '0;
               r_prem  <= '0;
               r_q     <= '0;
               if (w_dsr_zero) begin
                  r_quot <= DBZ_Q;
                  r_rem  <= '0;
                  r_ovf  <= 1'b0;
                  r_dbz  <= 1'b1;
               end
            end
            CALC: if (r_cnt != LAST) begin
               r_prem <= w_prem;
               r_q    <= {r_q[DW-2:0], w_qbit};
               r_dnd  <= {r_dnd[DW-2:0], 1'b0};
               r_cnt  <= r_cnt + CNT_WIDTH'(1);
            end else begin
               r_quot <= w_quot;
               r_rem  <= w_rem;
               r_ovf  <= w_ovf;
               r_dbz  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign quotient  = r_quot;
   assign remainder = r_rem;
   assign ovf       = r_ovf;
   assign dbz       = r_dbz;

endmodule

// File: tb/tb_paramest_nn_div_28s_12s_16u_seq.sv
// Directed self-checking bench for the sequential divider.
// Honours PARAMEST_DIV_SATURATE_EN for quotient expectations.
module tb_paramest_nn_div_28s_12s_16u_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [27:0] dividend = '0;
   logic [11:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] quotient;
   logic [11:0] remainder;
   logic        ovf;
   logic        dbz;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;
   logic [15:0] q_hold;

`ifdef PARAMEST_DIV_SATURATE_EN
   localparam logic [15:0] Q_NEG14 = 16'h0000;
   localparam logic [15:0] Q_BIG   = 16'hFFFF;
   localparam logic [15:0] Q_65536 = 16'hFFFF;
   localparam logic [15:0] Q_DBZ   = 16'hFFFF;
   localparam logic [15:0] Q_NEG7  = 16'h0000;
`else
   localparam logic [15:0] Q_NEG14 = 16'hFFF2;
   localparam logic [15:0] Q_BIG   = 16'h2345;
   localparam logic [15:0] Q_65536 = 16'h0000;
   localparam logic [15:0] Q_DBZ   = 16'h0000;
   localparam logic [15:0] Q_NEG7  = 16'hFFF9;
`endif

   paramest_nn_div_28s_12s_16u_seq dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .ovf       (ovf),
      .dbz       (dbz)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic start(input logic [27:0] dnd,
                        input logic [11:0] dsr);
      int k = 0;
      while (!in_ready && k < 100) begin
         @(posedge ap_clk); #1;
         k++;
      end
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      dividend = dnd;
      divisor  = dsr;
      in_valid = 1'b1;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int l);
      l = 0;
      while (!out_valid && l < 64) begin
         @(posedge ap_clk); #1;
         l++;
      end
      chk("out_valid_seen", 32'(out_valid), 32'd1);
   endtask

   task automatic check_res(input string tag,
                            input logic [15:0] q,
                            input logic [11:0] r,
                            input logic o,
                            input logic z);
      chk({tag, "_quot"}, 32'(quotient), 32'(q));
      chk({tag, "_rem"}, 32'(remainder), 32'(r));
      chk({tag, "_ovf"}, 32'(ovf), 32'(o));
      chk({tag, "_dbz"}, 32'(dbz), 32'(z));
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
      chk("idle_after_consume", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      check_res("rst", 16'd0, 12'd0, 1'b0, 1'b0);
      #13 ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;

      start(28'(-8638), 12'(-7));
      wait_out(lat);
      chk("t1_latency", 32'(lat), 32'd29);
      check_res("t1", 16'd1234, 12'd0, 1'b0, 1'b0);
      consume();

      start(28'h0012345, 12'd1);
      wait_out(lat);
      check_res("t3a", Q_BIG, 12'd0, 1'b1, 1'b0);
      consume();

      start(28'h8000000, 12'h800);
      wait_out(lat);
      check_res("t3b", Q_65536, 12'd0, 1'b1, 1'b0);
      consume();

      start(28'd500, 12'd0);
      chk("t4_dbz_latency", 32'(out_valid), 32'd1);
      check_res("t4", Q_DBZ, 12'd0, 1'b0, 1'b1);
      consume();

      start(28'd100, 12'd7);
      wait_out(lat);
      chk("t2a_latency", 32'(lat), 32'd29);
      check_res("t2a", 16'd14, 12'd2, 1'b0, 1'b0);
      consume();

      start(28'd100, 12'(-7));
      wait_out(lat);
      check_res("t2b", Q_NEG14, 12'd2, 1'b1, 1'b0);
      q_hold   = quotient;
      dividend = 28'd999;
      divisor  = 12'd3;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge ap_clk); #1;
         chk("t5_hold_valid", 32'(out_valid), 32'd1);
         chk("t5_hold_ready", 32'(in_ready), 32'd0);
         chk("t5_hold_quot", 32'(quotient), 32'(q_hold));
         chk("t5_hold_rem", 32'(remainder), 32'd2);
      end
      in_valid = 1'b0;
      consume();
      chk("t5_out_valid_low", 32'(out_valid), 32'd0);

      start(28'd12345, 12'd3);
      repeat (10) @(posedge ap_clk);
      #2 ap_rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
      check_res("t6_rst", 16'd0, 12'd0, 1'b0, 1'b0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      chk("t6_no_partial", 32'(out_valid), 32'd0);

      start(28'(-35), 12'd5);
      wait_out(lat);
      chk("t6_latency", 32'(lat), 32'd29);
      check_res("t6", Q_NEG7, 12'd0, 1'b1, 1'b0);
      consume();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
